// File: rtl/window_gen_3x3.sv
// window_gen_3x3: buffers two image rows of a raster 8-bit pixel stream and
// emits every interior 3x3 neighbourhood with its min/max, two cycles after
// the pixel that completes the window.
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CNT_W      = 12
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iFrameStart,
    input  logic       iPixelValid,
    input  logic [7:0] iv8Pixel,
    output logic [7:0] ov8Pixel_a,
    output logic [7:0] ov8Pixel_b,
    output logic [7:0] ov8Pixel_c,
    output logic [7:0] ov8Pixel_d,
    output logic [7:0] ov8Pixel_fij,
    output logic [7:0] ov8Pixel_e,
    output logic [7:0] ov8Pixel_f,
    output logic [7:0] ov8Pixel_g,
    output logic [7:0] ov8Pixel_h,
    output logic [7:0] ov8Minij,
    output logic [7:0] ov8Maxij,
    output logic       oDataValid,
    output logic       oEn,
    output logic       oFrameDone
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DONE} state_t;

    // Window index order: 0..8 = a,b,c,d,fij,e,f,g,h
    function automatic logic [7:0] win_min(input logic [7:0] w [9]);
        logic [7:0] m;
        m = w[0];
        for (int i = 1; i < 9; i++) begin
            if (w[i] < m) m = w[i];
        end
        return m;
    endfunction

    function automatic logic [7:0] win_max(input logic [7:0] w [9]);
        logic [7:0] m;
        m = w[0];
        for (int i = 1; i < 9; i++) begin
            if (w[i] > m) m = w[i];
        end
        return m;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic [7:0]       win_p1_q [9];
    logic [7:0]       win_p1_d [9];
    logic             vld_p1_q, vld_p1_d;
    logic             last_p1_q, last_p1_d;
    logic [7:0]       pix_p2_q [9];
    logic [7:0]       pix_p2_d [9];
    logic [7:0]       min_p2_q, min_p2_d, max_p2_q, max_p2_d;
    logic             vld_p2_q, vld_p2_d;
    logic             done_p2_q, done_p2_d;
    logic             vld_p3_q, vld_p3_d;

    logic [7:0]       lb1_mem [IMG_WIDTH];   // row r-1
    logic [7:0]       lb2_mem [IMG_WIDTH];   // row r-2

    logic             restart, accept, col_last, row_last;
    logic [CNT_W-1:0] cur_col, cur_row;
    logic [AW-1:0]    rd_addr;
    logic [7:0]       rd1, rd2;

    // Next-state, counters, window shift and output-stage staging
    always_comb begin
        restart  = iPixelValid & iFrameStart;
        accept   = iPixelValid & (iFrameStart | (state_q == FILL) | (state_q == ACTIVE));
        // A frame-start pixel is always coordinate (0,0), whatever the counters say
        cur_col  = restart ? '0 : col_q;
        cur_row  = restart ? '0 : row_q;
        col_last = (cur_col == CNT_W'(IMG_WIDTH - 1));
        row_last = (cur_row == CNT_W'(IMG_HEIGHT - 1));
        rd_addr  = cur_col[AW-1:0];
        rd1      = lb1_mem[rd_addr];
        rd2      = lb2_mem[rd_addr];

        state_d = state_q;
        case (state_q)
            IDLE: if (restart) state_d = FILL;
            FILL, ACTIVE: begin
                if (restart)
                    state_d = FILL;
                else if (accept && col_last && row_last)
                    state_d = DONE;
                else if (accept && col_last && (cur_row == CNT_W'(1)))
                    state_d = ACTIVE;
            end
            DONE: state_d = restart ? FILL : IDLE;
            default: state_d = IDLE;
        endcase

        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            col_d = col_last ? '0 : cur_col + CNT_W'(1);
            row_d = col_last ? cur_row + CNT_W'(1) : cur_row;
        end

        // ---- stage 1: window shift on each accepted pixel
        win_p1_d  = win_p1_q;
        vld_p1_d  = accept && (cur_row >= CNT_W'(2)) && (cur_col >= CNT_W'(2));
        last_p1_d = accept && col_last && row_last;
        if (accept) begin
            win_p1_d[0] = win_p1_q[1];
            win_p1_d[1] = win_p1_q[2];
            win_p1_d[2] = rd2;
            win_p1_d[3] = win_p1_q[4];
            win_p1_d[4] = win_p1_q[5];
            win_p1_d[5] = rd1;
            win_p1_d[6] = win_p1_q[7];
            win_p1_d[7] = win_p1_q[8];
            win_p1_d[8] = iv8Pixel;
        end

        // ---- stage 2: register window and min/max; runs even when input stalls
        pix_p2_d  = pix_p2_q;
        min_p2_d  = min_p2_q;
        max_p2_d  = max_p2_q;
        vld_p2_d  = vld_p1_q;
        done_p2_d = vld_p1_q & last_p1_q;
        if (vld_p1_q) begin
            pix_p2_d = win_p1_q;
            min_p2_d = win_min(win_p1_q);
            max_p2_d = win_max(win_p1_q);
        end

        // ---- stage 3: filter enable
        vld_p3_d = vld_p2_q;
    end

    // Control, window and output registers with asynchronous reset
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            min_p2_q  <= '0;
            max_p2_q  <= '0;
            vld_p2_q  <= 1'b0;
            done_p2_q <= 1'b0;
            vld_p3_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_p1_q[i] <= '0;
                pix_p2_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            vld_p1_q  <= vld_p1_d;
            last_p1_q <= last_p1_d;
            min_p2_q  <= min_p2_d;
            max_p2_q  <= max_p2_d;
            vld_p2_q  <= vld_p2_d;
            done_p2_q <= done_p2_d;
            vld_p3_q  <= vld_p3_d;
            win_p1_q  <= win_p1_d;
            pix_p2_q  <= pix_p2_d;
        end
    end

    // Line buffers: read-before-write at the same column shifts r-1 into r-2
    always_ff @(posedge iClk) begin
        if (accept) begin
            lb1_mem[rd_addr] <= iv8Pixel;
            lb2_mem[rd_addr] <= rd1;
        end
    end

    assign ov8Pixel_a   = pix_p2_q[0];
    assign ov8Pixel_b   = pix_p2_q[1];
    assign ov8Pixel_c   = pix_p2_q[2];
    assign ov8Pixel_d   = pix_p2_q[3];
    assign ov8Pixel_fij = pix_p2_q[4];
    assign ov8Pixel_e   = pix_p2_q[5];
    assign ov8Pixel_f   = pix_p2_q[6];
    assign ov8Pixel_g   = pix_p2_q[7];
    assign ov8Pixel_h   = pix_p2_q[8];
    assign ov8Minij     = min_p2_q;
    assign ov8Maxij     = max_p2_q;
    assign oDataValid   = vld_p2_q;
    assign oEn          = vld_p3_q;
    assign oFrameDone   = done_p2_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: directed table-driven bench for window_gen_3x3 on a 5x4 image.
module tb_window_gen_3x3;

    localparam int W = 5;
    localparam int H = 4;
    localparam logic [7:0] F = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       fs, pv;
    logic [7:0] pix;
    logic [7:0] oa, ob, oc, od, ofij, oe, of, og, oh, omin, omax;
    logic       odv, oen, odone;

    window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(12)) dut (
        .iClk(clk), .iRst(rst), .iFrameStart(fs), .iPixelValid(pv), .iv8Pixel(pix),
        .ov8Pixel_a(oa), .ov8Pixel_b(ob), .ov8Pixel_c(oc),
        .ov8Pixel_d(od), .ov8Pixel_fij(ofij), .ov8Pixel_e(oe),
        .ov8Pixel_f(of), .ov8Pixel_g(og), .ov8Pixel_h(oh),
        .ov8Minij(omin), .ov8Maxij(omax),
        .oDataValid(odv), .oEn(oen), .oFrameDone(odone)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic [87:0] w;} win_t;
    typedef struct {int trig; logic [87:0] exp;} vec_t;

    win_t got[$];
    int   done_cyc[$];
    int   en_err = 0;
    logic prev_dv = 1'b0;
    int   pcyc[64];
    int   pidx = 0;
    int   n_chk = 0, n_pass = 0;
    vec_t ramp_tab[6];
    vec_t flat_tab[6];

    // Output monitor, sampled 2 time units after each rising edge
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            if (oen !== prev_dv) en_err++;
            if (odv) got.push_back('{cyc, {oa, ob, oc, od, ofij, oe, of, og, oh, omin, omax}});
            if (odone) done_cyc.push_back(cyc);
        end
        prev_dv = odv;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic f, input logic [7:0] p);
        @(posedge clk);
        #1;
        pv = v; fs = f; pix = p;
        if (v) begin
            pcyc[pidx] = cyc;
            pidx++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear();
        got.delete();
        done_cyc.delete();
        en_err = 0;
        pidx = 0;
    endtask

    task automatic check_frame(input string name, input int off, input int base, input int kind);
        vec_t v;
        for (int k = 0; k < 6; k++) begin
            v = (kind == 0) ? ramp_tab[k] : flat_tab[k];
            if (off + k < got.size()) begin
                chk($sformatf("%s_win%0d", name, k), 128'(got[off+k].w), 128'(v.exp));
                chk($sformatf("%s_lat%0d", name, k), 128'(got[off+k].cyc), 128'(pcyc[base+v.trig] + 2));
            end else begin
                n_chk++;
                $display("FAIL %s_win%0d: window missing, have %0d required %0d", name, k, got.size(), off + k + 1);
            end
        end
    endtask

    task automatic check_done(input string name, input int idx, input int win_idx);
        if (idx < done_cyc.size() && win_idx < got.size())
            chk({name, "_done_cyc"}, 128'(done_cyc[idx]), 128'(got[win_idx].cyc));
        else begin
            n_chk++;
            $display("FAIL %s_done_cyc: done pulses %0d windows %0d", name, done_cyc.size(), got.size());
        end
    endtask

    initial begin
        ramp_tab[0] = '{12, {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12, 8'd0, 8'd12}};
        ramp_tab[1] = '{13, {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd1, 8'd13}};
        ramp_tab[2] = '{14, {8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd2, 8'd14}};
        ramp_tab[3] = '{17, {8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12, 8'd15, 8'd16, 8'd17, 8'd5, 8'd17}};
        ramp_tab[4] = '{18, {8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd16, 8'd17, 8'd18, 8'd6, 8'd18}};
        ramp_tab[5] = '{19, {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19, 8'd7, 8'd19}};
        // Constant 255 frame with pixel (1,1)=0: every window containing (1,1) has min 0
        flat_tab[0] = '{12, {F, F, F, F, 8'd0, F, F, F, F, 8'd0, F}};
        flat_tab[1] = '{13, {F, F, F, 8'd0, F, F, F, F, F, 8'd0, F}};
        flat_tab[2] = '{14, {F, F, F, F, F, F, F, F, F, F, F}};
        flat_tab[3] = '{17, {F, 8'd0, F, F, F, F, F, F, F, 8'd0, F}};
        flat_tab[4] = '{18, {8'd0, F, F, F, F, F, F, F, F, 8'd0, F}};
        flat_tab[5] = '{19, {F, F, F, F, F, F, F, F, F, F, F}};

        rst = 1'b1; fs = 1'b0; pv = 1'b0; pix = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 128'({oa, ob, oc, od, ofij, oe, of, og, oh, omin, omax, odv, oen, odone}), 128'(0));
        rst = 1'b0;

        // Continuous ramp, preceded by pixels without frame start that must be ignored
        clear();
        drive(1'b1, 1'b0, 8'h77);
        drive(1'b1, 1'b0, 8'h78);
        pidx = 0;
        for (int i = 0; i < 20; i++) drive(1'b1, i == 0, 8'(i));
        idle(6);
        chk("ramp_count", 128'(got.size()), 128'(6));
        check_frame("ramp", 0, 0, 0);
        chk("ramp_done_count", 128'(done_cyc.size()), 128'(1));
        check_done("ramp", 0, 5);
        chk("ramp_en", 128'(en_err), 128'(0));

        // Ramp with a gap after every pixel; frame start is asserted in gaps and must be ignored
        clear();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, i == 0, 8'(i));
            if (i < 19) drive(1'b0, 1'b1, 8'hAA);
        end
        idle(6);
        chk("gap_count", 128'(got.size()), 128'(6));
        check_frame("gap", 0, 0, 0);
        chk("gap_done_count", 128'(done_cyc.size()), 128'(1));
        check_done("gap", 0, 5);
        chk("gap_en", 128'(en_err), 128'(0));

        // Constant frame with a single zero at (1,1)
        clear();
        for (int i = 0; i < 20; i++) drive(1'b1, i == 0, (i == 6) ? 8'd0 : 8'd255);
        idle(6);
        chk("flat_count", 128'(got.size()), 128'(6));
        check_frame("flat", 0, 0, 1);
        chk("flat_done_count", 128'(done_cyc.size()), 128'(1));

        // Frame restarted at pixel 9, then a complete frame
        clear();
        for (int i = 0; i < 9; i++) drive(1'b1, i == 0, 8'(i + 100));
        pidx = 0;
        for (int i = 0; i < 20; i++) drive(1'b1, i == 0, 8'(i));
        idle(6);
        chk("abort_count", 128'(got.size()), 128'(6));
        check_frame("abort", 0, 0, 0);
        chk("abort_done_count", 128'(done_cyc.size()), 128'(1));
        check_done("abort", 0, 5);

        // Reset pulsed while pixel 14 is presented; pixel 12's window is due that cycle
        clear();
        for (int i = 0; i < 14; i++) drive(1'b1, i == 0, 8'(i));
        @(posedge clk);
        #1;
        rst = 1'b1; pv = 1'b1; fs = 1'b0; pix = 8'd14;
        #1;
        chk("midrst_outputs", 128'({oa, ob, oc, od, ofij, oe, of, og, oh, omin, omax, odv, oen, odone}), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 15; i < 20; i++) drive(1'b1, 1'b0, 8'(i));
        idle(6);
        chk("midrst_windows", 128'(got.size()), 128'(0));
        chk("midrst_done", 128'(done_cyc.size()), 128'(0));

        // Two back-to-back frames with no idle cycle between them
        clear();
        for (int i = 0; i < 40; i++) drive(1'b1, (i % 20) == 0, 8'(i % 20));
        idle(6);
        chk("b2b_count", 128'(got.size()), 128'(12));
        check_frame("b2b_f1", 0, 0, 0);
        check_frame("b2b_f2", 6, 20, 0);
        chk("b2b_done_count", 128'(done_cyc.size()), 128'(2));
        check_done("b2b_f1", 0, 5);
        check_done("b2b_f2", 1, 11);
        chk("b2b_en", 128'(en_err), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
